// File: rtl/c2h_pkg.sv
// Shared constants and FSM state type for the C2H frame serializer.
package c2h_pkg;

  localparam int C2H_IN_W    = 4072;
  localparam int C2H_FRAME_W = 4096;
  localparam int C2H_DATA_W  = 512;
  localparam int C2H_BEATS   = C2H_FRAME_W / C2H_DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } c2h_state_t;

endpackage

// File: rtl/c2h_frame_serializer_beat_mux.sv
// Combinational DATA_W-wide slice select of the padded frame buffer by beat index.
module c2h_beat_mux #(
  parameter int FRAME_W = 4096,
  parameter int DATA_W  = 512,
  parameter int IDX_W   = 3
) (
  input  logic [FRAME_W-1:0] frame_buf,
  input  logic [IDX_W-1:0]   beat_idx,
  output logic [DATA_W-1:0]  tdata
);

  localparam int BEATS = FRAME_W / DATA_W;

  logic [DATA_W-1:0] slices [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_slice
    assign slices[g] = frame_buf[g*DATA_W +: DATA_W];
  end

  // BEATS is a power of two, so every beat_idx value selects a real slice.
  assign tdata = slices[beat_idx];

endmodule

// File: rtl/c2h_frame_serializer.sv
// Pads one packed C2H frame to FRAME_W bits and streams it as AXI4-Stream beats.
// Optional frame-number sequence checker enabled by defining C2H_SEQ_CHECK_EN.
module c2h_frame_serializer
  import c2h_pkg::*;
#(
  parameter int IN_W    = C2H_IN_W,
  parameter int FRAME_W = C2H_FRAME_W,
  parameter int DATA_W  = C2H_DATA_W,
  parameter int CNT_W   = 32
) (
  input  logic                  m_axis_c2h_aclk,
  input  logic                  m_axis_c2h_aresetn,
  input  logic                  en,
  input  logic [IN_W-1:0]       data,
  input  logic                  data_valid,
  output logic                  data_next,
  output logic [DATA_W-1:0]     m_axis_c2h_tdata,
  output logic [DATA_W/8-1:0]   m_axis_c2h_tkeep,
  output logic                  m_axis_c2h_tvalid,
  output logic                  m_axis_c2h_tlast,
  input  logic                  m_axis_c2h_tready,
  output logic                  busy,
  output logic                  overrun,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  seq_err
);

  localparam int BEATS = FRAME_W / DATA_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  c2h_state_t         state;
  logic [FRAME_W-1:0] frame_buf;
  logic [IDX_W-1:0]   beat_idx;

  assign m_axis_c2h_tkeep = '1;

  c2h_beat_mux #(
    .FRAME_W (FRAME_W),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_beat_mux (
    .frame_buf (frame_buf),
    .beat_idx  (beat_idx),
    .tdata     (m_axis_c2h_tdata)
  );

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state             <= IDLE;
      frame_buf         <= '0;
      beat_idx          <= '0;
      m_axis_c2h_tvalid <= 1'b0;
      m_axis_c2h_tlast  <= 1'b0;
      data_next         <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
      frame_cnt         <= '0;
    end else if (en) begin
      // Channel reset: abandon any partial frame without signalling data_next.
      state             <= IDLE;
      beat_idx          <= '0;
      m_axis_c2h_tvalid <= 1'b0;
      m_axis_c2h_tlast  <= 1'b0;
      data_next         <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
      frame_cnt         <= '0;
    end else begin
      data_next <= 1'b0;
      if (data_valid && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (data_valid) begin
            frame_buf         <= FRAME_W'(data);
            beat_idx          <= '0;
            m_axis_c2h_tvalid <= 1'b1;
            m_axis_c2h_tlast  <= (BEATS == 1);
            busy              <= 1'b1;
            state             <= SEND;
          end
        end
        SEND: begin
          if (m_axis_c2h_tready) begin
            beat_idx <= beat_idx + IDX_W'(1);
            if (beat_idx == LAST_IDX) begin
              m_axis_c2h_tvalid <= 1'b0;
              m_axis_c2h_tlast  <= 1'b0;
              data_next         <= 1'b1;
              state             <= DONE;
            end else begin
              m_axis_c2h_tlast <= (beat_idx + IDX_W'(1) == LAST_IDX);
            end
          end
        end
        DONE: begin
          frame_cnt <= frame_cnt + CNT_W'(1);
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef C2H_SEQ_CHECK_EN
  logic [7:0] exp_num;
  logic       exp_vld;

  // First capture after reset/en only seeds the expected number.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      exp_num <= '0;
      exp_vld <= 1'b0;
      seq_err <= 1'b0;
    end else if (en) begin
      exp_num <= '0;
      exp_vld <= 1'b0;
      seq_err <= 1'b0;
    end else if ((state == IDLE) && data_valid) begin
      if (exp_vld && (data[7:0] != exp_num)) seq_err <= 1'b1;
      exp_num <= data[7:0] + 8'd1;
      exp_vld <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule
